// File: rtl/route_pkg.sv
// -----------------------------------------------------------------------------
// route_pkg
// Shared definitions for the route controller: controller state encoding,
// BLE command opcodes and the barcode station-ID format tag.
// No ports (package).
// -----------------------------------------------------------------------------
package route_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        MOVE = 2'b10
    } state_t;

    localparam logic [1:0] OP_STOP   = 2'b00;
    localparam logic [1:0] OP_GO     = 2'b01;
    localparam logic [1:0] OP_APPEND = 2'b10;

    // Upper two bits of a barcode word that marks it as a station ID
    localparam logic [1:0] ID_FMT    = 2'b00;

endpackage

// File: rtl/route_dest_fifo.sv
// -----------------------------------------------------------------------------
// dest_fifo
// Circular destination queue with wrap-around pointers.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   flush      empty the queue (highest priority)
//   load       empty the queue and store din as its only entry
//   push, pop  append din / drop head; a push on a full queue succeeds only
//              when a pop happens in the same cycle
//   din        station to push/load
//   dout       head entry (valid when !empty)
//   cnt        number of stored entries, saturates at QDEPTH
//   full, empty
// -----------------------------------------------------------------------------
module dest_fifo #(
    parameter int QDEPTH = 4,
    parameter int ID_W   = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    load,
    input  logic                    push,
    input  logic                    pop,
    input  logic [ID_W-1:0]         din,
    output logic [ID_W-1:0]         dout,
    output logic [$clog2(QDEPTH):0] cnt,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(QDEPTH);

    logic [ID_W-1:0] r_mem [QDEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_cnt;
    logic            w_do_pop;
    logic            w_do_push;

    assign empty     = (r_cnt == {(AW+1){1'b0}});
    assign full      = (r_cnt == (AW+1)'(QDEPTH));
    assign w_do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rd_ptr];
    assign cnt       = r_cnt;

    // Pointer and occupancy update; flush beats load beats push/pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_cnt    <= {(AW+1){1'b0}};
        end else if (load) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= AW'(1);
            r_cnt    <= (AW+1)'(1);
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Entry storage; contents need no reset because the count gates reads
    always_ff @(posedge clk) begin
        if (!flush && load) begin
            r_mem[0] <= din;
        end else if (!flush && w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/route_cntrl.sv
// -----------------------------------------------------------------------------
// route_cntrl
// Command and control unit for the line follower: accepts BLE route commands
// into a destination queue, walks the route as barcode station IDs arrive,
// and drives go / in_transit / piezo buzzer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_rdy, cmd             BLE command ([7:6] opcode, [ID_W-1:0] station)
//   clr_cmd_rdy              one-cycle acknowledge of an accepted command
//   ID_vld, ID               barcode station ID
//   clr_ID_vld               one-cycle acknowledge of an accepted ID
//   OK2Move                  proximity sensor, path clear
//   go, in_transit           motion enable, route active
//   buzz, buzz_n             complementary piezo drive while blocked
//   cur_dest, q_cnt, q_ovf   current target, queued entries, sticky overflow
//   arrived                  one-cycle pulse on reaching cur_dest
// -----------------------------------------------------------------------------
module route_cntrl
    import route_pkg::*;
#(
    parameter int QDEPTH   = 4,
    parameter int ID_W     = 6,
    parameter int BUZZ_DIV = 12500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_rdy,
    input  logic [7:0]              cmd,
    output logic                    clr_cmd_rdy,
    input  logic                    ID_vld,
    input  logic [7:0]              ID,
    output logic                    clr_ID_vld,
    input  logic                    OK2Move,
    output logic                    go,
    output logic                    in_transit,
    output logic                    buzz,
    output logic                    buzz_n,
    output logic [ID_W-1:0]         cur_dest,
    output logic [$clog2(QDEPTH):0] q_cnt,
    output logic                    q_ovf,
    output logic                    arrived
);

    localparam int DW = $clog2(BUZZ_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(BUZZ_DIV - 1);

    state_t          r_state;
    logic            r_in_transit;
    logic            r_clr_cmd;
    logic            r_clr_id;
    logic            r_arrived;
    logic            r_q_ovf;
    logic [ID_W-1:0] r_cur_dest;
    logic [DW-1:0]   r_div;
    logic            r_buzz;

    logic            w_cmd_acc;
    logic            w_id_acc;
    logic            w_stop;
    logic            w_go_cmd;
    logic            w_append;
    logic            w_match;
    logic            w_pop;
    logic            w_drop;
    logic            w_buzz_act;
    logic            w_q_full;
    logic            w_q_empty;
    logic [ID_W-1:0] w_q_dout;

    dest_fifo #(
        .QDEPTH (QDEPTH),
        .ID_W   (ID_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (w_stop),
        .load  (w_go_cmd),
        .push  (w_append),
        .pop   (w_pop),
        .din   (cmd[ID_W-1:0]),
        .dout  (w_q_dout),
        .cnt   (q_cnt),
        .full  (w_q_full),
        .empty (w_q_empty)
    );

    // Handshake acceptance, command decode and arrival detection
    always_comb begin
        w_cmd_acc  = cmd_rdy & ~r_clr_cmd;
        w_id_acc   = ID_vld & ~r_clr_id;
        w_stop     = w_cmd_acc & (cmd[7:6] == OP_STOP);
        w_go_cmd   = w_cmd_acc & (cmd[7:6] == OP_GO);
        w_append   = w_cmd_acc & (cmd[7:6] == OP_APPEND);
        w_match    = w_id_acc & (r_state == MOVE) & (ID[7:6] == ID_FMT) &
                     (ID[ID_W-1:0] == r_cur_dest);
        // STOP/GO rewrite the queue, so they suppress any head pop
        w_pop      = ~w_stop & ~w_go_cmd & ~w_q_empty &
                     ((r_state == LOAD) | ((r_state == MOVE) & w_match));
        w_drop     = w_append & w_q_full & ~w_pop;
        w_buzz_act = r_in_transit & ~OK2Move;
    end

    // Route FSM with its registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_in_transit <= 1'b0;
            r_clr_cmd    <= 1'b0;
            r_clr_id     <= 1'b0;
            r_arrived    <= 1'b0;
            r_q_ovf      <= 1'b0;
            r_cur_dest   <= {ID_W{1'b0}};
        end else begin
            r_clr_cmd <= w_cmd_acc;
            r_clr_id  <= w_id_acc;
            r_arrived <= w_match;

            if (w_stop || w_go_cmd) r_q_ovf <= 1'b0;
            else if (w_drop)        r_q_ovf <= 1'b1;
            else                    r_q_ovf <= r_q_ovf;

            if (w_pop) r_cur_dest <= w_q_dout;
            else       r_cur_dest <= r_cur_dest;

            if (w_stop) begin
                r_state      <= IDLE;
                r_in_transit <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state      <= w_q_empty ? IDLE : LOAD;
                        r_in_transit <= 1'b0;
                    end
                    LOAD: begin
                        if (w_go_cmd) begin
                            r_state      <= LOAD;
                            r_in_transit <= 1'b0;
                        end else if (!w_q_empty) begin
                            r_state      <= MOVE;
                            r_in_transit <= 1'b1;
                        end else begin
                            r_state      <= IDLE;
                            r_in_transit <= 1'b0;
                        end
                    end
                    MOVE: begin
                        if (w_go_cmd) begin
                            r_state      <= LOAD;
                            r_in_transit <= 1'b0;
                        end else if (w_match && w_q_empty) begin
                            r_state      <= IDLE;
                            r_in_transit <= 1'b0;
                        end else begin
                            r_state      <= MOVE;
                            r_in_transit <= 1'b1;
                        end
                    end
                    default: begin
                        r_state      <= IDLE;
                        r_in_transit <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Buzzer half-period divider; held cleared while not blocked
    always_ff @(posedge clk) begin
        if (rst || !w_buzz_act) begin
            r_div  <= {DW{1'b0}};
            r_buzz <= 1'b0;
        end else if (r_div == DIV_MAX) begin
            r_div  <= {DW{1'b0}};
            r_buzz <= ~r_buzz;
        end else begin
            r_div  <= r_div + DW'(1);
            r_buzz <= r_buzz;
        end
    end

    assign clr_cmd_rdy = r_clr_cmd;
    assign clr_ID_vld  = r_clr_id;
    assign arrived     = r_arrived;
    assign q_ovf       = r_q_ovf;
    assign cur_dest    = r_cur_dest;
    assign in_transit  = r_in_transit;
    assign go          = r_in_transit & OK2Move;
    // Both piezo legs idle low when silent, complementary when sounding
    assign buzz        = w_buzz_act & r_buzz;
    assign buzz_n      = w_buzz_act & ~r_buzz;

endmodule

// File: tb/tb_route_cntrl.sv
// -----------------------------------------------------------------------------
// tb_route_cntrl
// Self-checking bench for route_cntrl: directed route scenarios followed by
// randomized traffic, all compared every cycle against a queue-based model.
// -----------------------------------------------------------------------------
module tb_route_cntrl;

    localparam int QDEPTH   = 4;
    localparam int ID_W     = 6;
    localparam int BUZZ_DIV = 12500;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_rdy;
    logic [7:0] cmd;
    logic       clr_cmd_rdy;
    logic       ID_vld;
    logic [7:0] ID;
    logic       clr_ID_vld;
    logic       OK2Move;
    logic       go;
    logic       in_transit;
    logic       buzz;
    logic       buzz_n;
    logic [ID_W-1:0] cur_dest;
    logic [$clog2(QDEPTH):0] q_cnt;
    logic       q_ovf;
    logic       arrived;

    always #5 clk = ~clk;

    route_cntrl #(
        .QDEPTH   (QDEPTH),
        .ID_W     (ID_W),
        .BUZZ_DIV (BUZZ_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .clr_cmd_rdy (clr_cmd_rdy),
        .ID_vld      (ID_vld),
        .ID          (ID),
        .clr_ID_vld  (clr_ID_vld),
        .OK2Move     (OK2Move),
        .go          (go),
        .in_transit  (in_transit),
        .buzz        (buzz),
        .buzz_n      (buzz_n),
        .cur_dest    (cur_dest),
        .q_cnt       (q_cnt),
        .q_ovf       (q_ovf),
        .arrived     (arrived)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: route as a list of stations plus a few flags
    logic [5:0] m_q[$];
    logic [5:0] m_dest;
    bit m_transit, m_fetch, m_ovf, m_clr_cmd, m_clr_id, m_arrived, m_phase;
    int m_div;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs presented this cycle
    task automatic model_step();
        bit cmd_acc, id_acc, hit, stop, gocmd, app;
        logic [5:0] st;
        if (rst) begin
            m_q.delete();
            m_dest = 6'd0; m_transit = 0; m_fetch = 0; m_ovf = 0;
            m_clr_cmd = 0; m_clr_id = 0; m_arrived = 0; m_phase = 0; m_div = 0;
            return;
        end
        cmd_acc = cmd_rdy && !m_clr_cmd;
        id_acc  = ID_vld && !m_clr_id;
        st      = cmd[5:0];
        stop    = cmd_acc && cmd[7:6] == 2'd0;
        gocmd   = cmd_acc && cmd[7:6] == 2'd1;
        app     = cmd_acc && cmd[7:6] == 2'd2;
        hit     = id_acc && m_transit && ID[7:6] == 2'd0 && ID[5:0] == m_dest;

        if (m_transit && !OK2Move) begin
            m_div++;
            if (m_div == BUZZ_DIV) begin
                m_div = 0;
                m_phase = !m_phase;
            end
        end else begin
            m_div = 0;
            m_phase = 0;
        end

        m_arrived = hit;
        m_clr_cmd = cmd_acc;
        m_clr_id  = id_acc;

        if (stop) begin
            m_q.delete();
            m_transit = 0; m_fetch = 0; m_ovf = 0;
        end else if (gocmd) begin
            m_fetch = m_transit || m_fetch || (m_q.size() > 0);
            m_transit = 0;
            m_q.delete();
            m_q.push_back(st);
            m_ovf = 0;
        end else begin
            if (m_fetch) begin
                m_fetch = 0;
                if (m_q.size() > 0) begin
                    m_dest = m_q.pop_front();
                    m_transit = 1;
                end
            end else if (m_transit) begin
                if (hit) begin
                    if (m_q.size() > 0) m_dest = m_q.pop_front();
                    else m_transit = 0;
                end
            end else if (m_q.size() > 0) begin
                m_fetch = 1;
            end
            if (app) begin
                if (m_q.size() < QDEPTH) m_q.push_back(st);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("clr_cmd_rdy", clr_cmd_rdy, m_clr_cmd);
        chk("clr_ID_vld", clr_ID_vld, m_clr_id);
        chk("arrived", arrived, m_arrived);
        chk("in_transit", in_transit, m_transit);
        chk("go", go, m_transit && OK2Move);
        chk("buzz", buzz, m_transit && !OK2Move && m_phase);
        chk("buzz_n", buzz_n, m_transit && !OK2Move && !m_phase);
        chk("cur_dest", cur_dest, m_dest);
        chk("q_cnt", q_cnt, m_q.size());
        chk("q_ovf", q_ovf, m_ovf);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // One idle cycle (lets any acknowledge drop), then present cmd and/or ID once
    task automatic send(input bit c_en, input logic [7:0] c, input bit i_en, input logic [7:0] id);
        cyc();
        cmd_rdy = c_en; cmd = c; ID_vld = i_en; ID = id;
        cyc();
        cmd_rdy = 1'b0; ID_vld = 1'b0;
    endtask

    initial begin
        int edges, last;
        logic prev;
        rst = 1'b1; cmd_rdy = 1'b0; cmd = 8'h00; ID_vld = 1'b0; ID = 8'h00; OK2Move = 1'b1;
        idle(2);
        chk("rst_in_transit", in_transit, 0);
        chk("rst_q_cnt", q_cnt, 0);
        chk("rst_go", go, 0);
        chk("rst_clr_cmd", clr_cmd_rdy, 0);
        rst = 1'b0;

        // GO 5: ack pulse, then in_transit two cycles after acceptance
        send(1'b1, 8'h45, 1'b0, 8'h00);
        chk("go5_clr", clr_cmd_rdy, 1);
        cyc();
        chk("go5_clr_drop", clr_cmd_rdy, 0);
        chk("go5_not_yet", in_transit, 0);
        cyc();
        chk("go5_transit", in_transit, 1);
        chk("go5_dest", cur_dest, 5);
        chk("go5_go", go, 1);

        // Multi-station route 5 -> 7 -> 9
        send(1'b1, 8'h87, 1'b0, 8'h00);
        send(1'b1, 8'h89, 1'b0, 8'h00);
        send(1'b0, 8'h00, 1'b1, 8'h05);
        chk("r_arr5", arrived, 1);
        chk("r_dest7", cur_dest, 7);
        chk("r_qcnt1", q_cnt, 1);
        chk("r_idack", clr_ID_vld, 1);
        send(1'b0, 8'h00, 1'b1, 8'h09);
        chk("r_ign9_arr", arrived, 0);
        chk("r_ign9_dest", cur_dest, 7);
        send(1'b0, 8'h00, 1'b1, 8'h07);
        chk("r_dest9", cur_dest, 9);
        send(1'b0, 8'h00, 1'b1, 8'h09);
        chk("r_end_arr", arrived, 1);
        chk("r_end_idle", in_transit, 0);

        // Overflow: 5 appends on a 4-deep queue
        send(1'b1, 8'h41, 1'b0, 8'h00);
        idle(2);
        for (int k = 0; k < 5; k++) send(1'b1, 8'(8'h8A + k), 1'b0, 8'h00);
        chk("ovf_qcnt", q_cnt, 4);
        chk("ovf_flag", q_ovf, 1);
        send(1'b0, 8'h00, 1'b1, 8'h01);
        send(1'b0, 8'h00, 1'b1, 8'h0A);
        send(1'b0, 8'h00, 1'b1, 8'h0B);
        send(1'b0, 8'h00, 1'b1, 8'h0C);
        chk("ovf_last_dest", cur_dest, 8'h0D);
        chk("ovf_drained", q_cnt, 0);
        send(1'b1, 8'h00, 1'b0, 8'h00);
        chk("stop_ovf", q_ovf, 0);
        chk("stop_qcnt", q_cnt, 0);
        chk("stop_transit", in_transit, 0);

        // Buzzer while blocked
        send(1'b1, 8'h42, 1'b0, 8'h00);
        idle(2);
        OK2Move = 1'b0;
        edges = 0; last = 0; prev = buzz;
        for (int i = 1; i <= 60000; i++) begin
            cyc();
            if (buzz !== prev) begin
                edges++;
                chk("buzz_gap", i - last, BUZZ_DIV);
                last = i;
                prev = buzz;
            end
        end
        chk("buzz_edges", edges, 4);
        chk("buzz_compl", buzz_n, !buzz);
        chk("blocked_go", go, 0);
        OK2Move = 1'b1;
        cyc();
        chk("clear_buzz", buzz, 0);
        chk("clear_buzz_n", buzz_n, 0);
        chk("clear_go", go, 1);

        // STOP and matching ID in the same cycle
        send(1'b1, 8'h83, 1'b0, 8'h00);
        send(1'b1, 8'h00, 1'b1, 8'h02);
        chk("sx_clr_cmd", clr_cmd_rdy, 1);
        chk("sx_clr_id", clr_ID_vld, 1);
        chk("sx_arrived", arrived, 1);
        chk("sx_idle", in_transit, 0);
        chk("sx_qcnt", q_cnt, 0);

        // Full queue + arrival pop + APPEND 3 in the same cycle
        send(1'b1, 8'h54, 1'b0, 8'h00);
        idle(2);
        for (int k = 0; k < 4; k++) send(1'b1, 8'(8'h95 + k), 1'b0, 8'h00);
        chk("fp_full", q_cnt, 4);
        send(1'b1, 8'h83, 1'b1, 8'h14);
        chk("fp_qcnt", q_cnt, 4);
        chk("fp_ovf", q_ovf, 0);
        chk("fp_dest", cur_dest, 8'h15);
        for (int k = 0; k < 4; k++) send(1'b0, 8'h00, 1'b1, 8'(8'h15 + k));
        chk("fp_tail", cur_dest, 3);
        chk("fp_tail_qcnt", q_cnt, 0);
        rst = 1'b1;
        cyc();
        chk("mrst_transit", in_transit, 0);
        chk("mrst_dest", cur_dest, 0);
        chk("mrst_go", go, 0);
        chk("mrst_arrived", arrived, 0);
        chk("mrst_clr_id", clr_ID_vld, 0);
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            OK2Move = ($urandom_range(0, 99) < 85);
            cmd_rdy = ($urandom_range(0, 99) < 35);
            cmd     = {2'($urandom), 6'($urandom_range(0, 7))};
            ID_vld  = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 1) == 1) ID = {2'b00, m_dest};
            else ID = 8'($urandom);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/route_cntrl.md
Name: route_cntrl

Overview:
- Next-generation command and control unit for the follower.
- Replaces single-destination command handling with a parametrised destination queue, so one BLE session can load a multi-station route.
- Sits between the BLE112 command interface, the barcode station-ID reader and the proximity sensor; drives go, in_transit and the piezo buzzer.
- Also reports queue status and arrival events for LEDs and debug.

Parameters:
- QDEPTH, 4, destination queue depth in entries (power of 2, ≥2).
- ID_W, 6, station ID width carried in cmd[ID_W-1:0] and ID[ID_W-1:0] (≤6).
- BUZZ_DIV, 12500, clk cycles per buzzer half-period (2 kHz at 50 MHz).

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous active-high reset
- cmd_rdy  in  1  BLE command valid
- cmd  in  8  BLE command: [7:6] opcode, [ID_W-1:0] station
- clr_cmd_rdy  out  1  one-cycle pulse; command consumed
- ID_vld  in  1  barcode ID valid
- ID  in  8  station ID from barcode unit
- clr_ID_vld  out  1  one-cycle pulse; ID consumed
- OK2Move  in  1  proximity sensor: path clear
- go  out  1  enable to motion controller
- in_transit  out  1  route active; enables proximity sensor
- buzz, buzz_n  out  1 each  complementary piezo drive
- cur_dest  out  ID_W  destination currently being sought
- q_cnt  out  $clog2(QDEPTH)+1  queued entries, excluding cur_dest
- q_ovf  out  1  sticky: an append was dropped
- arrived  out  1  one-cycle pulse on reaching cur_dest

Behaviour:
- Reset (synchronous, rst=1 at posedge): all outputs 0, state IDLE, queue empty.
- Opcodes:
  - 00 STOP: flush queue, go to IDLE, clear q_ovf.
  - 01 GO: flush queue, push station, clear q_ovf.
  - 10 APPEND: push station. If full and no pop in the same cycle, drop it and set q_ovf.
  - 11: ignored.
  - Every opcode, including 11, is acknowledged.
- Cmd handshake:
  - The command is accepted on any cycle with cmd_rdy=1 and clr_cmd_rdy=0.
  - clr_cmd_rdy is registered high for exactly the next cycle.
  - The same rule applies to ID_vld/clr_ID_vld.
- States: IDLE, LOAD, MOVE.
  - IDLE: in_transit=0. If q_cnt>0, go to LOAD.
  - LOAD: pop head into cur_dest, go to MOVE. Takes one cycle; go is first possible the cycle after LOAD.
  - MOVE: in_transit=1; go = OK2Move (combinational with registered state).
  - MOVE, on accepted ID with ID[7:6]==2'b00 and ID[ID_W-1:0]==cur_dest:
    - arrived pulses one cycle later.
    - If q_cnt>0: pop the next entry into cur_dest the same cycle and stay in MOVE.
    - Otherwise go to IDLE.
  - Non-matching or malformed IDs are acknowledged and ignored. IDs received in IDLE are acknowledged and ignored.
- Simultaneous events:
  - STOP plus matching ID in the same cycle: STOP wins; IDLE, no pop. arrived still pulses.
  - GO while in MOVE: flush, then LOAD the new station next cycle.
  - APPEND plus arrival-pop on a full queue: both succeed; q_cnt unchanged.
- Buzzer:
  - Active iff in_transit=1 and OK2Move=0.
  - While active: buzz toggles every BUZZ_DIV cycles and buzz_n = ~buzz.
  - While inactive: buzz=0, buzz_n=0, and the divider counter is cleared.
- Queue: circular with wrap-around pointers; q_cnt saturates at QDEPTH.

Decomposition:
- route_pkg:
  - state enum {IDLE, LOAD, MOVE}
  - opcode localparams OP_STOP=2'b00, OP_GO=2'b01, OP_APPEND=2'b10
  - station-format constant ID_FMT=2'b00
- Sub-module dest_fifo (parameters QDEPTH, ID_W):
  - push, pop, flush, dout, cnt, full, empty.
  - flush has priority over push/pop in the same cycle; route_cntrl sequences GO as flush, then push next cycle.
  - Alternatively, dest_fifo supports flush+push as "load single". Decided: dest_fifo has a load input (flush and write one entry, cnt=1).

Test Plan:
- Reset with rst=1 for 2 cycles: all outputs 0, q_cnt=0. cmd_rdy=1 with cmd=8'h45 (GO 5): clr_cmd_rdy pulses 1 cycle; in_transit=1 two cycles after acceptance; cur_dest=5; go=1 with OK2Move=1.
- GO 5, APPEND 7, APPEND 9, then ID 8'h05: arrived pulse, cur_dest=7, q_cnt=1. Then ID 8'h09: ignored. Then ID 8'h07: cur_dest=9. Then ID 8'h09: IDLE, in_transit=0.
- QDEPTH=4, in MOVE: 5 APPENDs: q_cnt=4, q_ovf=1, 5th entry never reached. Then STOP: q_ovf=0, q_cnt=0, in_transit=0.
- In MOVE with OK2Move=0 for 60000 cycles (BUZZ_DIV=12500): go=0; buzz toggles at 12500-cycle intervals (4 edges); buzz_n=~buzz. OK2Move=1: buzz=buzz_n=0, go=1.
- Same cycle: cmd_rdy with STOP and ID_vld matching cur_dest, queue non-empty: both clr pulses, arrived=1, state IDLE, q_cnt=0.
- Full queue (4) plus matching ID plus APPEND 3 in the same cycle: q_cnt stays 4, q_ovf=0, 3 is the tail entry. Assert rst mid-MOVE: next cycle all outputs 0.
